flash_ctrl: RTL
===============

FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 SHALL have parameter P_FIFO_DEPTH, default 256, write-byte buffer depth.
REQ-002 SHALL have parameter P_ADDR_W, default 24, flash address width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_operation_type, input, 2, operation code: 0=read, 1=page program, 2=sector erase, 3=reserved.
REQ-006 SHALL have port i_operation_addr, input, P_ADDR_W, byte address.
REQ-007 SHALL have port i_operation_num, input, 9, byte count, 1..256.
REQ-008 SHALL have ports i_operation_valid (input, 1) and o_operation_ready (output, 1), the operation handshake.
REQ-009 SHALL have ports i_write_data (input, 8), i_write_sop, i_write_eop and i_write_valid (input, 1 each), the program-data stream.
REQ-010 SHALL have ports o_read_data (output, 8), o_read_sop, o_read_eop and o_read_valid (output, 1 each), the read-data stream.
REQ-011 SHALL have ports o_spi_byte (output, 8), o_spi_valid (output, 1), o_spi_last (output, 1; CS released after this byte) and i_spi_ready (input, 1), the byte path to the SPI driver.
REQ-012 SHALL have ports i_spi_rx_byte (input, 8) and i_spi_rx_valid (input, 1), one pulse per completed exchanged byte.

Function
REQ-013 SHALL accept an operation on a cycle with i_operation_valid && o_operation_ready; o_operation_ready SHALL be high only in IDLE.
REQ-014 SHALL transfer a byte to the SPI driver only on a cycle with o_spi_valid && i_spi_ready; o_spi_byte and o_spi_last SHALL be held stable while o_spi_valid is high and i_spi_ready is low.
REQ-015 SHALL implement FSM states IDLE, WAIT_DATA, WREN, CMD, ADDR, DATA_TX, DATA_RX, POLL, DONE.
REQ-016 On a read, SHALL go IDLE->CMD(0x03)->ADDR->DATA_RX->DONE->IDLE, in one CS frame.
REQ-017 On a page program, SHALL go IDLE->WAIT_DATA->WREN(0x06, last)->CMD(0x02)->ADDR->DATA_TX->POLL->DONE.
REQ-018 On a sector erase, SHALL go IDLE->WREN->CMD(0x20)->ADDR(last on final byte)->POLL->DONE.
REQ-019 SHALL send the address as 3 bytes, MSB first.
REQ-020 In DATA_RX, SHALL send num bytes of 0x00, with o_spi_last on the final byte.
REQ-021 SHALL ignore the first 4 rx pulses of a read frame and forward the next num rx bytes to o_read_data, 1-cycle latency.
REQ-022 SHALL assert o_read_sop with the first forwarded byte and o_read_eop with the last.
REQ-023 In WAIT_DATA, SHALL store write bytes in the FIFO until i_write_eop or num bytes are stored, whichever comes first.
REQ-024 SHALL discard write bytes beyond num, and write bytes arriving outside WAIT_DATA.
REQ-025 On an early eop, SHALL program only the bytes received.
REQ-026 In DATA_TX, SHALL pop the FIFO, with o_spi_last on the final data byte.
REQ-027 In POLL, SHALL send frame 0x05, 0x00(last); rx byte 2 bit0=1 SHALL repeat the frame, bit0=0 SHALL go to DONE.
REQ-028 A num=0 operation or type 3 SHALL be accepted, produce no SPI traffic, and return to IDLE via DONE.
REQ-029 DONE SHALL last exactly 1 cycle, then return to IDLE.
REQ-030 A read-data overrun SHALL be impossible; read data has no backpressure.

Reset
REQ-031 On i_rst, SHALL enter IDLE, flush the FIFO, and clear all counters.
REQ-032 Reset values SHALL be: o_operation_ready=0 during reset and 1 on the first cycle after; o_spi_valid=0, o_spi_last=0, o_spi_byte=0; o_read_*=0.
REQ-033 Reset mid-operation SHALL abort with no further bytes issued; the SPI driver is reset by the same i_rst.

Structure
REQ-034 Command opcodes (0x03, 0x02, 0x20, 0x06, 0x05), operation-type codes and state encodings SHALL live in a shared package flash_pkg.
REQ-035 The write buffer SHALL be one sub-module, flash_sync_fifo (8-bit wide, P_FIFO_DEPTH deep, full/empty flags); all other logic in flash_ctrl.

Verification
REQ-036 Read addr 0x123456, num 4; driver echoes rx 0xAA,0xBB,0xCC,0xDD after 4 header bytes -> SPI bytes 03 12 34 56 00 00 00 00 (last on 8th); o_read sop@0xAA, eop@0xDD.
REQ-037 Program addr 0x000100, num 3, data 11 22 33 (eop on 33); status 0x01 then 0x00 -> frames [06], [02 00 01 00 11 22 33], [05 00], [05 00]; DONE once.
REQ-038 Erase addr 0x010000; status 0x00 -> frames [06], [20 01 00 00], [05 00].
REQ-039 Program num 4, eop after 2 bytes -> DATA_TX sends 2 bytes only; a 5th byte in a num-4 stream is dropped.
REQ-040 i_spi_ready held low 5 cycles mid-ADDR -> o_spi_byte stable; no byte lost or duplicated.
REQ-041 i_rst asserted during DATA_TX -> next cycle o_spi_valid=0; then o_operation_ready=1 and the FIFO is empty.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared opcodes, operation codes and FSM encoding for the SPI flash controller.
package flash_pkg;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_PP   = 8'h02;
   localparam logic [7:0] CMD_SE   = 8'h20;
   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_RDSR = 8'h05;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_PROG  = 2'd1,
      OP_ERASE = 2'd2,
      OP_RSVD  = 2'd3
   } op_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_WREN,
      ST_CMD,
      ST_ADDR,
      ST_DATA_TX,
      ST_DATA_RX,
      ST_POLL,
      ST_DONE
   } state_t;

   // Address goes out MSB first: index 0 is bits [23:16].
   function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = addr[23:16];
         2'd1:    b = addr[15:8];
         default: b = addr[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/flash_sync_fifo.sv
// Byte-wide synchronous FIFO holding page-program data; read data is the current head.
module flash_sync_fifo #(
   parameter int unsigned P_DEPTH = 256
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int unsigned AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam int unsigned CW = $clog2(P_DEPTH + 1);

   logic [7:0]    mem_q [P_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok, pop_ok;

   assign o_full  = (cnt_q == CW'(P_DEPTH));
   assign o_empty = (cnt_q == '0);
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;
   assign o_data  = mem_q[rd_ptr_q];

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= (wr_ptr_q == AW'(P_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= (rd_ptr_q == AW'(P_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/flash_ctrl.sv
// SPI NOR flash command sequencer: read, page program and sector erase with
// status polling, feeding a byte-level SPI driver.
module flash_ctrl
   import flash_pkg::*;
#(
   parameter int unsigned P_FIFO_DEPTH = 256,
   parameter int unsigned P_ADDR_W     = 24
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_operation_type,
   input  logic [P_ADDR_W-1:0] i_operation_addr,
   input  logic [8:0]          i_operation_num,
   input  logic                i_operation_valid,
   output logic                o_operation_ready,
   input  logic [7:0]          i_write_data,
   input  logic                i_write_sop,
   input  logic                i_write_eop,
   input  logic                i_write_valid,
   output logic [7:0]          o_read_data,
   output logic                o_read_sop,
   output logic                o_read_eop,
   output logic                o_read_valid,
   output logic [7:0]          o_spi_byte,
   output logic                o_spi_valid,
   output logic                o_spi_last,
   input  logic                i_spi_ready,
   input  logic [7:0]          i_spi_rx_byte,
   input  logic                i_spi_rx_valid
);

   state_t      state_q;
   op_t         op_q;
   logic [23:0] addr_q;
   logic [8:0]  num_q, idx_q, wr_cnt_q, fwd_q, pend_q, skip_q, pend_nxt;
   logic [2:0]  hdr_q;
   logic        prx_q, rdy_q;
   logic [7:0]  spi_byte_q, rd_data_q;
   logic        spi_valid_q, spi_last_q;
   logic        rd_valid_q, rd_sop_q, rd_eop_q;

   logic        spi_fire, wr_take, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        rx_counted, rd_frame;
   logic        unused_sop;

   assign unused_sop = i_write_sop;

   assign o_operation_ready = rdy_q && !i_rst;
   assign o_spi_byte        = spi_byte_q;
   assign o_spi_valid       = spi_valid_q;
   assign o_spi_last        = spi_last_q;
   assign o_read_data       = rd_data_q;
   assign o_read_sop        = rd_sop_q;
   assign o_read_eop        = rd_eop_q;
   assign o_read_valid      = rd_valid_q;

   always_comb begin
      spi_fire   = spi_valid_q && i_spi_ready;
      wr_take    = (state_q == ST_WAIT_DATA) && i_write_valid && (wr_cnt_q < num_q) && !fifo_full;
      fifo_pop   = spi_fire && !fifo_empty &&
                   (((state_q == ST_ADDR) && (idx_q == 9'd2) && (op_q == OP_PROG)) ||
                    ((state_q == ST_DATA_TX) && (idx_q < wr_cnt_q)));
      rx_counted = i_spi_rx_valid && ((pend_q != '0) || spi_fire);
      pend_nxt   = pend_q + {8'd0, spi_fire} - {8'd0, rx_counted};
      rd_frame   = (op_q == OP_READ) &&
                   ((state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA_RX));
   end

   flash_sync_fifo #(.P_DEPTH(P_FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (wr_take),
      .i_data  (i_write_data),
      .i_pop   (fifo_pop),
      .o_data  (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         addr_q      <= '0;
         num_q       <= '0;
         idx_q       <= '0;
         wr_cnt_q    <= '0;
         fwd_q       <= '0;
         pend_q      <= '0;
         skip_q      <= '0;
         hdr_q       <= '0;
         prx_q       <= 1'b0;
         rdy_q       <= 1'b1;
         spi_byte_q  <= '0;
         spi_valid_q <= 1'b0;
         spi_last_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_sop_q    <= 1'b0;
         rd_eop_q    <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         rd_sop_q   <= 1'b0;
         rd_eop_q   <= 1'b0;
         pend_q     <= pend_nxt;

         // The first four rx bytes of a read frame echo command and address.
         if (i_spi_rx_valid && rd_frame) begin
            if (hdr_q != 3'd4) begin
               hdr_q <= hdr_q + 3'd1;
            end else if (fwd_q != num_q) begin
               rd_data_q  <= i_spi_rx_byte;
               rd_valid_q <= 1'b1;
               rd_sop_q   <= (fwd_q == '0);
               rd_eop_q   <= (fwd_q + 9'd1 == num_q);
               fwd_q      <= fwd_q + 9'd1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (i_operation_valid && rdy_q) begin
                  rdy_q    <= 1'b0;
                  op_q     <= op_t'(i_operation_type);
                  addr_q   <= 24'(i_operation_addr);
                  num_q    <= i_operation_num;
                  idx_q    <= '0;
                  wr_cnt_q <= '0;
                  hdr_q    <= '0;
                  fwd_q    <= '0;
                  if (i_operation_num == '0 || op_t'(i_operation_type) == OP_RSVD) begin
                     state_q <= ST_DONE;
                  end else begin
                     case (op_t'(i_operation_type))
                        OP_READ: begin
                           state_q <= ST_CMD;
                           {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b0, CMD_READ};
                        end
                        OP_PROG: state_q <= ST_WAIT_DATA;
                        default: begin
                           state_q <= ST_WREN;
                           {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b1, CMD_WREN};
                        end
                     endcase
                  end
               end
            end

            ST_WAIT_DATA: begin
               if (wr_take) begin
                  wr_cnt_q <= wr_cnt_q + 9'd1;
                  if (i_write_eop || (wr_cnt_q + 9'd1 == num_q)) begin
                     state_q <= ST_WREN;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b1, CMD_WREN};
                  end
               end
            end

            ST_WREN: begin
               if (spi_fire) begin
                  state_q <= ST_CMD;
                  {spi_valid_q, spi_last_q, spi_byte_q} <=
                     {1'b1, 1'b0, (op_q == OP_PROG) ? CMD_PP : CMD_SE};
               end
            end

            ST_CMD: begin
               if (spi_fire) begin
                  state_q <= ST_ADDR;
                  idx_q   <= '0;
                  {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b0, addr_byte(addr_q, 2'd0)};
               end
            end

            ST_ADDR: begin
               if (spi_fire) begin
                  if (idx_q != 9'd2) begin
                     idx_q <= idx_q + 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <=
                        {1'b1, (op_q == OP_ERASE) && (idx_q == 9'd1),
                         addr_byte(addr_q, idx_q[1:0] + 2'd1)};
                  end else if (op_q == OP_READ) begin
                     state_q <= ST_DATA_RX;
                     idx_q   <= 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, num_q == 9'd1, 8'h00};
                  end else if (op_q == OP_PROG) begin
                     state_q <= ST_DATA_TX;
                     idx_q   <= 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, wr_cnt_q == 9'd1, fifo_rdata};
                  end else begin
                     state_q <= ST_POLL;
                     idx_q   <= '0;
                     prx_q   <= 1'b0;
                     skip_q  <= pend_nxt;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b0, CMD_RDSR};
                  end
               end
            end

            ST_DATA_TX: begin
               if (spi_fire) begin
                  if (idx_q < wr_cnt_q) begin
                     idx_q <= idx_q + 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <=
                        {1'b1, idx_q + 9'd1 == wr_cnt_q, fifo_rdata};
                  end else begin
                     state_q <= ST_POLL;
                     idx_q   <= '0;
                     prx_q   <= 1'b0;
                     skip_q  <= pend_nxt;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b0, CMD_RDSR};
                  end
               end
            end

            ST_DATA_RX: begin
               if (spi_fire) begin
                  if (idx_q < num_q) begin
                     idx_q <= idx_q + 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, idx_q + 9'd1 == num_q, 8'h00};
                  end else begin
                     {spi_valid_q, spi_last_q, spi_byte_q} <= '0;
                  end
               end
               if (!spi_valid_q && (fwd_q == num_q)) state_q <= ST_DONE;
            end

            ST_POLL: begin
               if (spi_fire) begin
                  if (idx_q == '0) begin
                     idx_q <= 9'd1;
                     {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b1, 8'h00};
                  end else begin
                     {spi_valid_q, spi_last_q, spi_byte_q} <= '0;
                  end
               end
               // Rx pulses still owed for bytes sent before this frame are skipped.
               if (i_spi_rx_valid) begin
                  if (skip_q != '0) begin
                     skip_q <= skip_q - 9'd1;
                  end else if (!prx_q) begin
                     prx_q <= 1'b1;
                  end else begin
                     prx_q <= 1'b0;
                     if (i_spi_rx_byte[0]) begin
                        idx_q  <= '0;
                        skip_q <= pend_nxt;
                        {spi_valid_q, spi_last_q, spi_byte_q} <= {1'b1, 1'b0, CMD_RDSR};
                     end else begin
                        state_q <= ST_DONE;
                     end
                  end
               end
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
               rdy_q   <= 1'b1;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
